// File: rtl/freq_counter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// programmable number of clk_in cycles, single-shot or back-to-back.
module freq_counter #(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sig_in,
  input  logic              start_in,
  input  logic              continuous_in,
  input  logic [GATE_W-1:0] gate_len_in,
  output logic [CNT_W-1:0]  count_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic              ovf_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               sync3_q, sync3_d;
  logic [GATE_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]   edges_q, edges_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               edge_det;

  // A programmed length of zero still opens a one-cycle gate.
  function automatic logic [GATE_W-1:0] load_len(input logic [GATE_W-1:0] n);
    return (n == '0) ? GATE_W'(1) : n;
  endfunction

  assign edge_det = sync2_q & ~sync3_q;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    state_d = state_q;
    timer_d = timer_q;
    edges_d = edges_q;
    flag_d  = flag_q;
    count_d = count_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = GATE;
          timer_d = load_len(gate_len_in);
          edges_d = '0;
          flag_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      GATE: begin
        // Saturate rather than wrap; a lost increment is remembered as overflow.
        if (edge_det) begin
          if (edges_q == '1) flag_d = 1'b1;
          else               edges_d = edges_q + CNT_W'(1);
        end
        timer_d = timer_q - GATE_W'(1);
        if (timer_q <= GATE_W'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        count_d = edges_q;
        ovf_d   = flag_q;
        valid_d = 1'b1;
        if (continuous_in) begin
          state_d = GATE;
          timer_d = load_len(gate_len_in);
          edges_d = '0;
          flag_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      timer_q <= '0;
      edges_q <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      timer_q <= timer_d;
      edges_q <= edges_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out = count_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: a 32-bit and a 4-bit instance share all inputs and
// are checked every cycle against a cycle-indexed gate/edge-count model.
module tb_freq_counter;

  logic        clk = 1'b0;
  logic        rst, sig, start, cont;
  logic [31:0] len;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        val_a, val_b, busy_a, busy_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  freq_counter #(.CNT_W(32), .GATE_W(32)) dut_a (
    .clk_in(clk), .rst_in(rst), .sig_in(sig), .start_in(start),
    .continuous_in(cont), .gate_len_in(len),
    .count_out(cnt_a), .valid_out(val_a), .busy_out(busy_a), .ovf_out(ovf_a));

  freq_counter #(.CNT_W(4), .GATE_W(32)) dut_b (
    .clk_in(clk), .rst_in(rst), .sig_in(sig), .start_in(start),
    .continuous_in(cont), .gate_len_in(len),
    .count_out(cnt_b), .valid_out(val_b), .busy_out(busy_b), .ovf_out(ovf_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus waveform for sig: 0 = square of period per, 1 = held, 2 = random
  int per = 10;
  int ph = 0;
  int smode = 0;
  bit shold = 1'b0;

  // Model: sample history (newest first), raw unsaturated edge count, gate window
  bit          sq[$];
  longint      raw;
  bit          open;
  int          e = 0;
  int          gate_end;
  int          report_edge;
  bit          ev, eb, eo32, eo4;
  logic [31:0] ec32;
  logic [3:0]  ec4;

  int nbusy = 0;
  int nval = 0;
  int last_val_e = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, e);
    end
  endtask

  function void model_reset();
    sq = {1'b0, 1'b0, 1'b0};
    raw = 0;
    open = 1'b0;
    report_edge = -1;
    ev = 1'b0; eb = 1'b0; eo32 = 1'b0; eo4 = 1'b0;
    ec32 = '0; ec4 = '0;
  endfunction

  function void start_gate();
    open = 1'b1;
    gate_end = e + ((len == 0) ? 1 : int'(len));
    raw = 0;
  endfunction

  // Edge e counts if the input sampled two edges earlier was high and three
  // edges earlier was low; the gate covers edges start+1 .. start+N.
  function void model_edge();
    bit det;
    e++;
    det = sq[1] & !sq[2];
    sq.push_front(sig);
    void'(sq.pop_back());
    ev = 1'b0;
    if (open) begin
      if (det) raw++;
      if (e == gate_end) begin
        open = 1'b0;
        report_edge = e + 1;
      end
    end else if (e == report_edge) begin
      ev = 1'b1;
      ec32 = (raw > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : raw[31:0];
      eo32 = (raw > 64'hFFFF_FFFF);
      ec4  = (raw > 15) ? 4'hF : raw[3:0];
      eo4  = (raw > 15);
      report_edge = -1;
      if (cont) start_gate();
    end else if (start) begin
      start_gate();
    end
    eb = open;
  endfunction

  task automatic compare();
    chk("busy_a", busy_a, eb);
    chk("busy_b", busy_b, eb);
    chk("valid_a", val_a, ev);
    chk("valid_b", val_b, ev);
    chk("count_a", cnt_a, ec32);
    chk("count_b", cnt_b, ec4);
    chk("ovf_a", ovf_a, eo32);
    chk("ovf_b", ovf_b, eo4);
    if (val_a) begin
      nval++;
      last_val_e = e;
    end
    if (busy_a) nbusy++;
  endtask

  task automatic drive_sig();
    case (smode)
      0: begin sig = ((ph % per) < per / 2); ph++; end
      1: sig = shold;
      default: sig = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    drive_sig();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k = 0;
    while (!val_a && k < budget) begin
      tick();
      k++;
    end
    if (!val_a) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no valid strobe within %0d cycles", nm, budget);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int e1;
    rst = 1'b1; start = 1'b0; cont = 1'b0; len = '0; sig = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_count", cnt_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_busy", busy_a, 0);

    // 1000-cycle gate on a clk/10 square wave
    smode = 0; per = 10; len = 1000;
    repeat (20) tick();
    nbusy = 0;
    pulse_start();
    wait_valid(1100, "gate1000");
    chk("gate1000_count", cnt_a, 100);
    chk("gate1000_ovf", ovf_a, 0);
    chk("gate1000_len", nbusy, 1000);
    tick();

    // Zero length behaves as one cycle; a held-high input yields no edges
    smode = 1; shold = 1'b1;
    repeat (6) tick();
    len = 0; nbusy = 0;
    pulse_start();
    wait_valid(10, "gate0");
    chk("gate0_count", cnt_a, 0);
    chk("gate0_len", nbusy, 1);
    tick();

    // Saturation of the 4-bit instance with 25 edges
    smode = 0; per = 4;
    repeat (12) tick();
    len = 100;
    pulse_start();
    wait_valid(200, "sat");
    chk("sat_count_b", cnt_b, 15);
    chk("sat_ovf_b", ovf_b, 1);
    chk("sat_count_a", cnt_a, 25);
    chk("sat_ovf_a", ovf_a, 0);
    tick();

    // Continuous gates of 50 on a clk/5 input, then stop mid-gate
    per = 5;
    repeat (10) tick();
    cont = 1'b1; len = 50;
    pulse_start();
    wait_valid(60, "cont1");
    chk("cont1_count", cnt_a, 10);
    e1 = last_val_e;
    tick();
    wait_valid(60, "cont2");
    chk("cont2_count", cnt_a, 10);
    chk("cont2_spacing", last_val_e - e1, 51);
    e1 = last_val_e;
    tick();
    repeat (20) tick();
    cont = 1'b0;
    wait_valid(60, "cont3");
    chk("cont3_count", cnt_a, 10);
    chk("cont3_spacing", last_val_e - e1, 51);
    tick();
    nbusy = 0;
    repeat (80) tick();
    chk("cont_stop_idle", nbusy, 0);

    // start_in and gate_len_in changes during a gate are ignored
    len = 30; nbusy = 0;
    pulse_start();
    repeat (5) tick();
    len = 7;
    pulse_start();
    wait_valid(100, "restart");
    chk("restart_len", nbusy, 30);
    tick();

    // Reset 20 cycles into a 100-cycle gate aborts without a report
    len = 100;
    pulse_start();
    repeat (18) tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("abort_busy", busy_a, 0);
    chk("abort_count", cnt_a, 0);
    chk("abort_valid", val_a, 0);
    nval = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (150) tick();
    chk("abort_no_valid", nval, 0);
    chk("abort_no_restart", busy_a, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) cont = ~cont;
      if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 40);
      if ($urandom_range(0, 99) == 0) begin
        smode = $urandom_range(0, 2);
        per = $urandom_range(2, 12);
        shold = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; cont = 1'b0;
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
